wr_buf_ctrl: RTL and testbench
==============================

Name: wr_buf_ctrl

Overview:
- Downstream consumer of the write-request FSM.
- Each single-cycle write strobe from that FSM pushes one data word into an internal FIFO.
- The block drains buffered words to the memory write port over a valid/ready handshake, tagging each word with a sequential, wrapping write address.
- It decouples strobe timing from memory back-pressure and reports full, empty and overflow status.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 4, width of memory write address. Address wraps modulo 2^ADDR_W.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- BASE_ADDR, 0, first address issued after reset. Width is ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_b  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe (wr_out of the request FSM); sampled every rising edge.
- wr_data  in  DATA_W  data pushed when wr_en=1.
- mem_wr_valid  out  1  output word and address are valid.
- mem_wr_addr  out  ADDR_W  write address of the presented word.
- mem_wr_data  out  DATA_W  presented word.
- mem_wr_ready  in  1  memory accepts the word when valid=1 and ready=1 at a rising edge.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries. The output register is not counted.
- overflow  out  1  sticky; set when a write strobe is dropped.
- count  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_b=0, asynchronous, takes effect immediately):
  - mem_wr_valid=0, mem_wr_addr=BASE_ADDR, mem_wr_data=0.
  - full=0, empty=1, overflow=0, count=0.
  - FSM=IDLE; FIFO pointers and address counter cleared.
  - Reset mid-transfer discards all buffered and presented data; no handshake completes.
- Push: on a rising edge with wr_en=1 and full=0, wr_data is written at the write pointer and count increments.
- Push when full=0 is false (full=1): the word is dropped, overflow sets to 1 and holds until reset, and count is unchanged. This applies even if a pop occurs in the same cycle.
- FSM states: IDLE, FETCH, PRESENT.
  - IDLE: mem_wr_valid=0. If empty=0 at the edge, go to FETCH.
  - FETCH: mem_wr_valid=0. Pop the head into the output register, decrement count, go to PRESENT.
  - PRESENT: mem_wr_valid=1. On valid&ready at the edge the transfer completes and mem_wr_addr increments (wrapping). Next state is FETCH if the FIFO is non-empty after that edge's push/pop accounting, otherwise IDLE. Without ready, stay in PRESENT.
- Stability: while mem_wr_valid=1 and ready=0, mem_wr_addr and mem_wr_data are held stable. valid never deasserts without a handshake, except on reset.
- Simultaneous push into an empty FIFO and handshake in PRESENT: the next state is FETCH, because the push is counted.
- Latency: a wr_en sampled at edge E0 into an idle, empty block gives mem_wr_valid=1 after edge E2, with mem_wr_data = the pushed word.
- Throughput: at most one word per 2 cycles.
- Status flags: full and empty are combinational from count. count changes only on edges.
- mem_wr_addr: the address counter value is output directly and increments only on completed handshakes. Dropped words consume no address.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH inclusive.
- X on wr_data while wr_en=0 must not propagate.

Test Plan:
- Reset values: assert rst_b=0 asynchronously mid-cycle -> all outputs at reset values immediately (valid=0, empty=1, count=0, addr=BASE_ADDR=0).
- Single write: wr_en=1 for 1 cycle with wr_data=0xA5, ready=1 -> valid rises after 2 edges with addr=0x0 and data=0xA5; handshake completes; valid=0 the next cycle; empty=1.
- Back-pressure: single write 0x3C, ready=0 for 4 cycles then 1 -> valid, addr=0 and data=0x3C stable for all 4 cycles; exactly one handshake; addr counter reads 1 afterwards.
- Burst: 4 consecutive strobes with data 0x11, 0x22, 0x33, 0x44 and ready=1 -> 4 handshakes in order, addr 0,1,2,3, spaced 2 cycles apart; overflow=0.
- Overflow: DEPTH=4, ready=0, 6 strobes (0x01..0x06):
  - The 1st word moves into the output register and 4 fill the FIFO, so full=1 and count=4.
  - The 6th strobe is dropped and overflow=1 (sticky).
  - After raising ready, words 0x01..0x05 emerge in order and 0x06 never does.
- Address wrap and reset: ADDR_W=2, 5 writes with ready=1 -> addresses 0,1,2,3,0. Then reset while valid=1 -> valid drops immediately and the next write is issued at addr=0.

Source files
------------

// File: rtl/wr_buf_ctrl_if.sv
// -----------------------------------------------------------------------------
// wr_buf_ctrl_if
//   Bundles the write-strobe input, the memory write handshake and the
//   buffer status signals of wr_buf_ctrl.
//
//   master : environment side (drives wr_en, wr_data, mem_wr_ready)
//   slave  : wr_buf_ctrl side (drives mem_wr_*, full, empty, overflow, count)
//
//   Parameters must match those of the wr_buf_ctrl instance it connects to.
// -----------------------------------------------------------------------------
interface wr_buf_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ready;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output wr_en,
        output wr_data,
        output mem_wr_ready,
        input  mem_wr_valid,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  full,
        input  empty,
        input  overflow,
        input  count
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  mem_wr_ready,
        output mem_wr_valid,
        output mem_wr_addr,
        output mem_wr_data,
        output full,
        output empty,
        output overflow,
        output count
    );
endinterface

// File: rtl/wr_buf_ctrl.sv
// -----------------------------------------------------------------------------
// wr_buf_ctrl
//   Buffers single-cycle write strobes in a small FIFO and drains them to a
//   memory write port over a valid/ready handshake. Each drained word is
//   tagged with a sequential address that wraps modulo 2^ADDR_W.
//
//   Ports:
//     clk   : system clock, rising-edge active
//     rst_b : asynchronous active-low reset
//     bus   : wr_buf_ctrl_if slave modport
//               wr_en / wr_data          write strobe and its data
//               mem_wr_valid/addr/data   presented word
//               mem_wr_ready             memory accepts the presented word
//               full / empty / count     FIFO occupancy (output reg excluded)
//               overflow                 sticky, a strobe was dropped
//
//   Drain sequence: IDLE -> FETCH (pop head into output register) ->
//   PRESENT (valid high until accepted) -> FETCH or IDLE.
// -----------------------------------------------------------------------------
module wr_buf_ctrl #(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          ADDR_W    = 4,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        rst_b,
    wr_buf_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPresent
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               overflow_q;

    logic full_w;
    logic empty_w;
    logic push;
    logic drop;
    logic pop;
    logic handshake;

    assign full_w    = (count_q == CNT_W'(DEPTH));
    assign empty_w   = (count_q == '0);
    // A strobe against a full FIFO is dropped even if a pop frees a slot on
    // the same edge; keeps the push decision independent of the drain side.
    assign push      = bus.wr_en & ~full_w;
    assign drop      = bus.wr_en & full_w;
    assign pop       = (state_q == StFetch) & ~empty_w;
    assign handshake = (state_q == StPresent) & bus.mem_wr_ready;

    // Occupancy after this edge's push/pop accounting.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty_w) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = empty_w ? StIdle : StPresent;
            end
            StPresent: begin
                // A push landing on the handshake edge counts, so an empty
                // FIFO receiving a word still goes straight to FETCH.
                if (handshake) begin
                    state_d = (count_d != '0) ? StFetch : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            if (handshake) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; only slots behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.mem_wr_valid = (state_q == StPresent);
    assign bus.mem_wr_addr  = addr_q;
    assign bus.mem_wr_data  = data_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.overflow     = overflow_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_wr_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_buf_ctrl
//   Directed bench for wr_buf_ctrl. A default-parameter instance runs a table
//   of per-cycle vectors plus hand-written back-pressure and async-reset
//   sequences; a second instance with ADDR_W=2 covers address wrap.
// -----------------------------------------------------------------------------
module tb_wr_buf_ctrl;

    logic clk;
    logic rst_b;

    wr_buf_ctrl_if #(.DATA_W(8), .ADDR_W(4), .DEPTH(4)) bus ();
    wr_buf_ctrl_if #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) bus2 ();

    wr_buf_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(4), .BASE_ADDR(4'd0)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    wr_buf_ctrl #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .BASE_ADDR(2'd0)) dut2 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failed;

    // Handshake monitors.
    int         hs1;
    logic [1:0] q2_addr [$];
    logic [7:0] q2_data [$];

    initial hs1 = 0;
    always @(posedge clk) begin
        if (bus.mem_wr_valid === 1'b1 && bus.mem_wr_ready === 1'b1) hs1 = hs1 + 1;
        if (bus2.mem_wr_valid === 1'b1 && bus2.mem_wr_ready === 1'b1) begin
            q2_addr.push_back(bus2.mem_wr_addr);
            q2_data.push_back(bus2.mem_wr_data);
        end
    end

    typedef struct {
        bit         rst;
        logic       en;
        logic [7:0] d;
        logic       rdy;
        logic       v;
        logic [3:0] a;
        logic [7:0] q;
        logic       f;
        logic       e;
        logic       o;
        logic [2:0] c;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input bit rst, input logic en, input logic [7:0] d, input logic rdy,
                       input logic v, input logic [3:0] a, input logic [7:0] q,
                       input logic f, input logic e, input logic o, input logic [2:0] c);
        vec_t x;
        x.rst = rst; x.en = en; x.d = d; x.rdy = rdy;
        x.v = v; x.a = a; x.q = q; x.f = f; x.e = e; x.o = o; x.c = c;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous-looking reset pulse; returns at a negedge with rst_b high.
    task automatic do_reset();
        @(negedge clk);
        rst_b             = 1'b0;
        bus.wr_en         = 1'b0;
        bus.mem_wr_ready  = 1'b0;
        bus2.wr_en        = 1'b0;
        bus2.mem_wr_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        failed = 0;
        rst_b  = 1'b0;
        bus.wr_en = 1'b0;  bus.wr_data = '0;  bus.mem_wr_ready = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_data = '0; bus2.mem_wr_ready = 1'b0;

        // Rows: {rst, en, d, rdy | v, addr, data, full, empty, ovf, count}.
        // Expected outputs are those seen before the edge that samples the inputs.
        // Single write 0xA5: valid two edges after the strobe.
        add(1, 1, 8'hA5, 1,  0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1,  1, 0, 8'hA5, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1,  0, 1, 8'h00, 0, 1, 0, 0);
        // Burst of four, one word every two cycles.
        add(1, 1, 8'h11, 1,  0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 1, 8'h22, 1,  0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 8'h33, 1,  0, 0, 8'h00, 0, 0, 0, 2);
        add(0, 1, 8'h44, 1,  1, 0, 8'h11, 0, 0, 0, 2);
        add(0, 0, 8'h00, 1,  0, 1, 8'h00, 0, 0, 0, 3);
        add(0, 0, 8'h00, 1,  1, 1, 8'h22, 0, 0, 0, 2);
        add(0, 0, 8'h00, 1,  0, 2, 8'h00, 0, 0, 0, 2);
        add(0, 0, 8'h00, 1,  1, 2, 8'h33, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1,  0, 3, 8'h00, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1,  1, 3, 8'h44, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1,  0, 4, 8'h00, 0, 1, 0, 0);
        // Overflow: six strobes with ready low, then a drop during a pop edge.
        add(1, 1, 8'h01, 0,  0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 1, 8'h02, 0,  0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 8'h03, 0,  0, 0, 8'h00, 0, 0, 0, 2);
        add(0, 1, 8'h04, 0,  1, 0, 8'h01, 0, 0, 0, 2);
        add(0, 1, 8'h05, 0,  1, 0, 8'h01, 0, 0, 0, 3);
        add(0, 1, 8'h06, 0,  1, 0, 8'h01, 1, 0, 0, 4);
        add(0, 0, 8'h00, 1,  1, 0, 8'h01, 1, 0, 1, 4);
        add(0, 1, 8'h77, 1,  0, 1, 8'h00, 1, 0, 1, 4);
        add(0, 0, 8'h00, 1,  1, 1, 8'h02, 0, 0, 1, 3);
        add(0, 0, 8'h00, 1,  0, 2, 8'h00, 0, 0, 1, 3);
        add(0, 0, 8'h00, 1,  1, 2, 8'h03, 0, 0, 1, 2);
        add(0, 0, 8'h00, 1,  0, 3, 8'h00, 0, 0, 1, 2);
        add(0, 0, 8'h00, 1,  1, 3, 8'h04, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1,  0, 4, 8'h00, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1,  1, 4, 8'h05, 0, 1, 1, 0);
        add(0, 0, 8'h00, 1,  0, 5, 8'h00, 0, 1, 1, 0);
        add(0, 0, 8'h00, 1,  0, 5, 8'h00, 0, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else @(negedge clk);
            bus.wr_en        = tbl[i].en;
            bus.wr_data      = tbl[i].en ? tbl[i].d : 8'hxx;
            bus.mem_wr_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.mem_wr_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_addr", i), 32'(bus.mem_wr_addr), 32'(tbl[i].a));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(tbl[i].f));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e));
            chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(tbl[i].o));
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].c));
            if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(bus.mem_wr_data), 32'(tbl[i].q));
        end

        // Back-pressure: word held stable for four cycles, exactly one handshake.
        do_reset();
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_data = 8'hxx;
        for (int k = 0; k < 10 && bus.mem_wr_valid !== 1'b1; k++) @(negedge clk);
        chk("bp_valid_rise", 32'(bus.mem_wr_valid), 32'd1);
        begin
            int hs_base;
            hs_base = hs1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("bp_hold%0d_valid", k), 32'(bus.mem_wr_valid), 32'd1);
                chk($sformatf("bp_hold%0d_addr", k), 32'(bus.mem_wr_addr), 32'd0);
                chk($sformatf("bp_hold%0d_data", k), 32'(bus.mem_wr_data), 32'h3C);
                @(negedge clk);
            end
            bus.mem_wr_ready = 1'b1;
            @(negedge clk);
            chk("bp_valid_after", 32'(bus.mem_wr_valid), 32'd0);
            repeat (3) @(negedge clk);
            chk("bp_hs_count", 32'(hs1 - hs_base), 32'd1);
            chk("bp_addr_after", 32'(bus.mem_wr_addr), 32'd1);
            chk("bp_empty_after", 32'(bus.empty), 32'd1);
        end

        // Asynchronous reset mid-cycle while full, overflowed and presenting.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(k);
            @(negedge clk);
        end
        bus.wr_en = 1'b0; bus.wr_data = 8'hxx;
        chk("pre_rst_valid", 32'(bus.mem_wr_valid), 32'd1);
        chk("pre_rst_full", 32'(bus.full), 32'd1);
        chk("pre_rst_overflow", 32'(bus.overflow), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.mem_wr_valid), 32'd0);
        chk("arst_addr", 32'(bus.mem_wr_addr), 32'd0);
        chk("arst_data", 32'(bus.mem_wr_data), 32'd0);
        chk("arst_full", 32'(bus.full), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_overflow", 32'(bus.overflow), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Address wrap on the ADDR_W=2 instance, then reset while presenting.
        do_reset();
        q2_addr.delete();
        q2_data.delete();
        bus2.mem_wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus2.wr_en = 1'b1; bus2.wr_data = 8'h51 + 8'(k);
            @(negedge clk);
        end
        bus2.wr_en = 1'b0; bus2.wr_data = 8'hxx;
        for (int k = 0; k < 40 && q2_addr.size() < 5; k++) @(negedge clk);
        chk("wrap_hs_count", 32'(q2_addr.size()), 32'd5);
        begin
            logic [1:0] exp_a [5];
            exp_a[0] = 2'd0; exp_a[1] = 2'd1; exp_a[2] = 2'd2; exp_a[3] = 2'd3; exp_a[4] = 2'd0;
            for (int k = 0; k < 5 && k < q2_addr.size(); k++) begin
                chk($sformatf("wrap%0d_addr", k), 32'(q2_addr[k]), 32'(exp_a[k]));
                chk($sformatf("wrap%0d_data", k), 32'(q2_data[k]), 32'(8'h51 + 8'(k)));
            end
        end
        bus2.mem_wr_ready = 1'b0;
        bus2.wr_en = 1'b1; bus2.wr_data = 8'h66;
        @(negedge clk);
        bus2.wr_en = 1'b0; bus2.wr_data = 8'hxx;
        for (int k = 0; k < 10 && bus2.mem_wr_valid !== 1'b1; k++) @(negedge clk);
        chk("wrap_pre_rst_valid", 32'(bus2.mem_wr_valid), 32'd1);
        chk("wrap_pre_rst_addr", 32'(bus2.mem_wr_addr), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("wrap_arst_valid", 32'(bus2.mem_wr_valid), 32'd0);
        chk("wrap_arst_addr", 32'(bus2.mem_wr_addr), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        bus2.mem_wr_ready = 1'b1;
        bus2.wr_en = 1'b1; bus2.wr_data = 8'h77;
        @(negedge clk);
        bus2.wr_en = 1'b0; bus2.wr_data = 8'hxx;
        for (int k = 0; k < 20 && q2_addr.size() < 6; k++) @(negedge clk);
        chk("post_rst_hs_count", 32'(q2_addr.size()), 32'd6);
        if (q2_addr.size() >= 6) begin
            chk("post_rst_addr", 32'(q2_addr[5]), 32'd0);
            chk("post_rst_data", 32'(q2_data[5]), 32'h77);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
